// File: rtl/fp_rf_pkg.sv
// Shared types and helpers for the FP register file / scoreboard.
// Optional same-cycle writeback forwarding is enabled by FP_RF_BYPASS_EN.
package fp_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 4;

  typedef struct packed {
    logic                 busy;
    logic [DEF_TAG_W-1:0] tag;
  } sb_entry_t;

  function automatic int aw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int src_idx(input int lane, input int s);
    return 2 * lane + s;
  endfunction

  function automatic int src_lsb(input int lane, input int s,
                                 input int w);
    return src_idx(lane, s) * w;
  endfunction

endpackage

// File: rtl/fp_rf_src_lookup.sv
// Per-source read resolution: earlier-lane rename, optional
// writeback forwarding (FP_RF_BYPASS_EN) and register-0 masking.
module fp_rf_src_lookup
  import fp_rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREGS   = 32,
  parameter int NLANE   = 2,
  parameter int NWB     = 2,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int R0_ZERO = 1,
  parameter int LANE    = 0
) (
  input  logic [aw_of(NREGS)-1:0]       addr,
  input  logic [DATA_W-1:0]             rd_data,
  input  logic                          rd_busy,
  input  logic [TAG_W-1:0]              rd_tag,
  input  logic [NLANE-1:0]              disp_we,
  input  logic [NLANE*aw_of(NREGS)-1:0] disp_addr,
  input  logic [NLANE*TAG_W-1:0]        disp_tag,
`ifdef FP_RF_BYPASS_EN
  input  logic [NWB-1:0]                wb_we,
  input  logic [NWB*aw_of(NREGS)-1:0]   wb_addr,
  input  logic [NWB*DATA_W-1:0]         wb_data,
  input  logic [NWB*TAG_W-1:0]          wb_tag,
`endif
  output logic [DATA_W-1:0]             data,
  output logic                          busy,
  output logic [TAG_W-1:0]              tag
);

  localparam int AW = aw_of(NREGS);

  logic             claim;
  logic [TAG_W-1:0] ctag;
  logic             is_r0;

  assign is_r0 = (R0_ZERO != 0) && (addr == '0);

  always_comb begin
    claim = 1'b0;
    ctag  = '0;
    for (int j = 0; j < NLANE; j++) begin
      if (j < LANE && disp_we[j] &&
          disp_addr[j*AW +: AW] == addr) begin
        claim = 1'b1;
        ctag  = disp_tag[j*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    data = rd_data;
    busy = rd_busy;
    tag  = rd_tag;
`ifdef FP_RF_BYPASS_EN
    if (!claim) begin
      for (int p = 0; p < NWB; p++) begin
        if (wb_we[p] && wb_addr[p*AW +: AW] == addr) begin
          if (!rd_busy) begin
            data = wb_data[p*DATA_W +: DATA_W];
          end else if (wb_tag[p*TAG_W +: TAG_W] == rd_tag) begin
            data = wb_data[p*DATA_W +: DATA_W];
            busy = 1'b0;
          end
        end
      end
    end
`endif
    if (claim) begin
      busy = 1'b1;
      tag  = ctag;
    end
    if (is_r0) begin
      data = '0;
      busy = 1'b0;
      tag  = '0;
    end
  end

endmodule

// File: rtl/fp_rf_scoreboard.sv
// FP register file with per-register busy/producer-tag scoreboard.
// Define FP_RF_BYPASS_EN to forward same-cycle writeback to reads.
module fp_rf_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREGS   = 32,
  parameter int NLANE   = 2,
  parameter int NWB     = 2,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int R0_ZERO = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NLANE*2*aw_of(NREGS)-1:0] src_addr,
  output logic [NLANE*2*DATA_W-1:0]       src_data,
  output logic [NLANE*2-1:0]              src_busy,
  output logic [NLANE*2*TAG_W-1:0]        src_tag,
  input  logic [NLANE-1:0]                disp_we,
  input  logic [NLANE*aw_of(NREGS)-1:0]   disp_addr,
  input  logic [NLANE*TAG_W-1:0]          disp_tag,
  input  logic [NWB-1:0]                  wb_we,
  input  logic [NWB*aw_of(NREGS)-1:0]     wb_addr,
  input  logic [NWB*DATA_W-1:0]           wb_data,
  input  logic [NWB*TAG_W-1:0]            wb_tag
);

  localparam int AW = aw_of(NREGS);

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } sb_t;

  logic [DATA_W-1:0] data_q [NREGS];
  sb_t               sb_q   [NREGS];

  function automatic logic legal(input logic [AW-1:0] a);
    return !((R0_ZERO != 0) && (a == '0));
  endfunction

  // Later loop iterations override earlier ones: flush > disp > clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
        sb_q[r]   <= '0;
      end
    end else begin
      for (int p = 0; p < NWB; p++) begin
        if (wb_we[p] && legal(wb_addr[p*AW +: AW])) begin
          data_q[wb_addr[p*AW +: AW]] <=
            wb_data[p*DATA_W +: DATA_W];
          if (sb_q[wb_addr[p*AW +: AW]].busy &&
              sb_q[wb_addr[p*AW +: AW]].tag ==
              wb_tag[p*TAG_W +: TAG_W])
            sb_q[wb_addr[p*AW +: AW]].busy <= 1'b0;
        end
      end
      if (flush) begin
        for (int r = 0; r < NREGS; r++)
          sb_q[r].busy <= 1'b0;
      end else begin
        for (int l = 0; l < NLANE; l++) begin
          if (disp_we[l] && legal(disp_addr[l*AW +: AW])) begin
            sb_q[disp_addr[l*AW +: AW]].busy <= 1'b1;
            sb_q[disp_addr[l*AW +: AW]].tag  <=
              disp_tag[l*TAG_W +: TAG_W];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NLANE * 2; i++) begin : g_src
    logic [AW-1:0] a;
    assign a = src_addr[i*AW +: AW];

    fp_rf_src_lookup #(
      .DATA_W  (DATA_W),
      .NREGS   (NREGS),
      .NLANE   (NLANE),
      .NWB     (NWB),
      .TAG_W   (TAG_W),
      .R0_ZERO (R0_ZERO),
      .LANE    (i / 2)
    ) u_lookup (
      .addr      (a),
      .rd_data   (data_q[a]),
      .rd_busy   (sb_q[a].busy),
      .rd_tag    (sb_q[a].tag),
      .disp_we   (disp_we),
      .disp_addr (disp_addr),
      .disp_tag  (disp_tag),
`ifdef FP_RF_BYPASS_EN
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .wb_tag    (wb_tag),
`endif
      .data      (src_data[i*DATA_W +: DATA_W]),
      .busy      (src_busy[i]),
      .tag       (src_tag[i*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_fp_rf_scoreboard.sv
// Scoreboard bench for fp_rf_scoreboard: directed stimulus queues
// expected source reads, a monitor compares them against the DUT.
module tb_fp_rf_scoreboard;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NLANE  = 2;
  localparam int NWB    = 2;
  localparam int TAG_W  = 4;
  localparam int AW     = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NLANE*2*AW-1:0]     src_addr;
  logic [NLANE*2*DATA_W-1:0] src_data;
  logic [NLANE*2-1:0]        src_busy;
  logic [NLANE*2*TAG_W-1:0]  src_tag;
  logic [NLANE-1:0]          disp_we;
  logic [NLANE*AW-1:0]       disp_addr;
  logic [NLANE*TAG_W-1:0]    disp_tag;
  logic [NWB-1:0]            wb_we;
  logic [NWB*AW-1:0]         wb_addr;
  logic [NWB*DATA_W-1:0]     wb_data;
  logic [NWB*TAG_W-1:0]      wb_tag;

  fp_rf_scoreboard #(
    .DATA_W(DATA_W), .NREGS(NREGS), .NLANE(NLANE),
    .NWB(NWB), .TAG_W(TAG_W), .R0_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_addr(src_addr), .src_data(src_data),
    .src_busy(src_busy), .src_tag(src_tag),
    .disp_we(disp_we), .disp_addr(disp_addr),
    .disp_tag(disp_tag), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_tag(wb_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          src;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event chk_ev;

  task automatic clear_in();
    flush     = 1'b0;
    disp_we   = '0;
    disp_addr = '0;
    disp_tag  = '0;
    wb_we     = '0;
    wb_addr   = '0;
    wb_data   = '0;
    wb_tag    = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic rd(input int s, input int a);
    src_addr[s*AW +: AW] = AW'(a);
  endtask

  task automatic disp(input int l, input int a, input int t);
    disp_we[l]                 = 1'b1;
    disp_addr[l*AW +: AW]      = AW'(a);
    disp_tag[l*TAG_W +: TAG_W] = TAG_W'(t);
  endtask

  task automatic wb(input int p, input int a,
                    input logic [31:0] d, input int t);
    wb_we[p]                    = 1'b1;
    wb_addr[p*AW +: AW]         = AW'(a);
    wb_data[p*DATA_W +: DATA_W] = d;
    wb_tag[p*TAG_W +: TAG_W]    = TAG_W'(t);
  endtask

  task automatic expect_src(input string n, input int s,
                            input int a, input logic [31:0] d,
                            input logic b, input int t);
    exp_t e;
    rd(s, a);
    e = '{n, s, d, b, TAG_W'(t)};
    exp_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation when a read is sampled.
  initial begin
    exp_t        e;
    logic [31:0] ad;
    logic        ab;
    logic [3:0]  at;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ad = src_data[e.src*DATA_W +: DATA_W];
        ab = src_busy[e.src];
        at = src_tag[e.src*TAG_W +: TAG_W];
        n_checks++;
        if (ad !== e.data || ab !== e.busy || at !== e.tag) begin
          n_fail++;
          $display("FAIL %s: got data=%h busy=%b tag=%0d, need data=%h busy=%b tag=%0d",
                   e.name, ad, ab, at, e.data, e.busy, e.tag);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    src_addr = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_src("rst_f1", 0, 1, 32'h0, 1'b0, 0);
    expect_src("rst_f2", 1, 2, 32'h0, 1'b0, 0);
    expect_src("rst_f5", 2, 5, 32'h0, 1'b0, 0);
    expect_src("rst_f31", 3, 31, 32'h0, 1'b0, 0);

    cyc();
    wb(0, 1, 32'hAAAA0001, 0);
    wb(1, 2, 32'hBBBB0002, 0);
    disp(0, 8, 7);
    expect_src("idle_f9", 0, 9, 32'h0, 1'b0, 0);

    cyc();
    expect_src("wr_f1", 0, 1, 32'hAAAA0001, 1'b0, 0);
    expect_src("wr_f2", 1, 2, 32'hBBBB0002, 1'b0, 0);
    expect_src("disp_f8", 2, 8, 32'h0, 1'b1, 7);

    // Asynchronous reset checked mid-cycle, before any clock edge.
    cyc();
    rst = 1'b1;
    #2;
    expect_src("arst_f1", 0, 1, 32'h0, 1'b0, 0);
    expect_src("arst_f2", 1, 2, 32'h0, 1'b0, 0);
    expect_src("arst_f8", 2, 8, 32'h0, 1'b0, 0);
    #1;
    ->chk_ev;

    cyc();
    rst = 1'b0;
    disp(0, 3, 5);
    expect_src("own_claim_f3", 0, 3, 32'h0, 1'b0, 0);
    expect_src("rename_f3", 2, 3, 32'h0, 1'b1, 5);

    cyc();
    expect_src("busy_l0_f3", 0, 3, 32'h0, 1'b1, 5);
    expect_src("busy_l1_f3", 2, 3, 32'h0, 1'b1, 5);
    wb(0, 3, 32'h3F800000, 2);

    cyc();
    expect_src("stale_wb_f3", 0, 3, 32'h3F800000, 1'b1, 5);

    cyc();
    rd(0, 20);
    rd(2, 21);
    wb(1, 3, 32'h40000000, 5);

    cyc();
    expect_src("match_wb_f3", 0, 3, 32'h40000000, 1'b0, 5);

    cyc();
    disp(0, 7, 1);

    cyc();
    disp(1, 7, 9);
    wb(0, 7, 32'h12345678, 1);
`ifdef FP_RF_BYPASS_EN
    expect_src("disp_wb_rd_f7", 0, 7, 32'h12345678, 1'b0, 1);
`else
    expect_src("disp_wb_rd_f7", 0, 7, 32'h0, 1'b1, 1);
`endif

    cyc();
    expect_src("disp_wb_l0_f7", 0, 7, 32'h12345678, 1'b1, 9);
    expect_src("disp_wb_l1_f7", 2, 7, 32'h12345678, 1'b1, 9);

    cyc();
    disp(0, 10, 3);
    disp(1, 10, 4);
    expect_src("rename_f10", 2, 10, 32'h0, 1'b1, 3);

    cyc();
    expect_src("hi_lane_f10", 0, 10, 32'h0, 1'b1, 4);

    cyc();
    rd(0, 21);
    rd(2, 22);
    wb(0, 4, 32'h11111111, 0);
    wb(1, 4, 32'h22222222, 0);

    cyc();
    expect_src("wb_prio_f4", 0, 4, 32'h22222222, 1'b0, 0);
    wb(0, 0, 32'h0000DEAD, 0);
    disp(0, 0, 6);
    expect_src("r0_rename", 2, 0, 32'h0, 1'b0, 0);

    cyc();
    expect_src("r0_after", 0, 0, 32'h0, 1'b0, 0);

    cyc();
    rd(0, 23);
    disp(0, 6, 2);

    cyc();
    expect_src("pre_flush_f6", 0, 6, 32'h0, 1'b1, 2);
    rd(2, 23);
    flush = 1'b1;
    disp(0, 6, 3);

    cyc();
    expect_src("flush_f6", 0, 6, 32'h0, 1'b0, 2);
    expect_src("flush_f3", 1, 3, 32'h40000000, 1'b0, 5);
    expect_src("flush_f7", 2, 7, 32'h12345678, 1'b0, 9);
    expect_src("flush_f10", 3, 10, 32'h0, 1'b0, 4);

    cyc();
    rd(0, 24);
    rd(1, 25);
    disp(0, 6, 11);

    cyc();
    wb(0, 6, 32'hCAFEF00D, 11);
    wb(1, 4, 32'h55555555, 0);
`ifdef FP_RF_BYPASS_EN
    expect_src("byp_f6", 0, 6, 32'hCAFEF00D, 1'b0, 11);
    expect_src("byp_plain_f4", 1, 4, 32'h55555555, 1'b0, 0);
`else
    expect_src("byp_f6", 0, 6, 32'h0, 1'b1, 11);
    expect_src("byp_plain_f4", 1, 4, 32'h22222222, 1'b0, 0);
`endif

    cyc();
    expect_src("post_wb_f6", 0, 6, 32'hCAFEF00D, 1'b0, 11);
    expect_src("post_wb_f4", 1, 4, 32'h55555555, 1'b0, 0);

    cyc();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, need 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
